pipe_reg_skid: RTL

Parametrised pipeline stage register for the processor datapath: a WIDTH-bit register with valid/ready handshaking, synchronous flush, and an optional skid entry. It sits between pipeline stages, such as fetch/decode and decode/execute, and replaces the plain write-enabled 32-bit register. Back-pressure, bubble insertion and branch/hazard flush are handled here, not by the surrounding control logic. A saturating stall counter is included for performance debug.

---
 rtl/pipe_reg_pkg.sv | 18 +
 rtl/pipe_reg_entry.sv | 27 ++
 rtl/pipe_reg_skid.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pipe_reg_pkg.sv
// pipe_reg_pkg: shared state encoding, default sizes and stall-counter helper
// for the pipe_reg_skid pipeline stage register.
package pipe_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;

    function automatic logic [63:0] sat_inc(input logic [63:0] cnt, input logic [63:0] max);
        return (cnt >= max) ? cnt : cnt + 64'd1;
    endfunction

endpackage

// File: rtl/pipe_reg_entry.sv
// pipe_reg_entry: WIDTH-bit data register with load enable and asynchronous
// reset to RESET_VAL.
module pipe_reg_entry
    import pipe_reg_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_q <= RESET_VAL;
        else if (i_load)
            r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: valid/ready pipeline stage register with flush and a saturating
// stall counter; PIPE_REG_SKID_EN adds a skid entry and registers in_ready.
module pipe_reg_skid
    import pipe_reg_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_stall;
    logic             w_main_load;
    logic [WIDTH-1:0] w_main_d;
    logic [WIDTH-1:0] w_main_q;

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_stall    = r_out_valid && !out_ready && !flush;

`ifdef PIPE_REG_SKID_EN
    logic             r_in_ready;
    logic             w_skid_load;
    logic [WIDTH-1:0] w_skid_q;

    always_comb begin
        w_state_nxt = r_state;
        w_main_load = 1'b0;
        w_main_d    = in_data;
        w_skid_load = 1'b0;
        case (r_state)
            EMPTY: begin
                w_main_load = w_in_fire;
                w_state_nxt = w_in_fire ? ONE : EMPTY;
            end
            ONE: begin
                w_main_load = w_in_fire && w_out_fire;
                w_skid_load = w_in_fire && !w_out_fire;
                w_state_nxt = w_in_fire ? (w_out_fire ? ONE : TWO) : (w_out_fire ? EMPTY : ONE);
            end
            TWO: begin
                w_main_load = w_out_fire;
                w_main_d    = w_skid_q;
                w_state_nxt = w_out_fire ? ONE : TWO;
            end
            default: w_state_nxt = EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = EMPTY;
            w_main_load = 1'b0;
            w_skid_load = 1'b0;
        end
    end

    // Ready comes straight from a flop so no path runs from out_ready to in_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_in_ready <= 1'b1;
        else
            r_in_ready <= (w_state_nxt != TWO);
    end

    pipe_reg_entry #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_skid_load),
        .i_d    (in_data),
        .o_q    (w_skid_q)
    );

    assign in_ready = r_in_ready;
`else
    always_comb begin
        w_state_nxt = r_state;
        w_main_load = 1'b0;
        w_main_d    = in_data;
        case (r_state)
            EMPTY: begin
                w_main_load = w_in_fire;
                w_state_nxt = w_in_fire ? ONE : EMPTY;
            end
            ONE: begin
                w_main_load = w_in_fire;
                w_state_nxt = (w_out_fire && !w_in_fire) ? EMPTY : ONE;
            end
            default: w_state_nxt = EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = EMPTY;
            w_main_load = 1'b0;
        end
    end

    assign in_ready = (r_state == EMPTY) || out_ready;
`endif

    pipe_reg_entry #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_main_load),
        .i_d    (w_main_d),
        .o_q    (w_main_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt != EMPTY);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_stall_cnt <= '0;
        else if (stat_clr)
            r_stall_cnt <= '0;
        else if (w_stall)
            r_stall_cnt <= CNT_W'(sat_inc(64'(r_stall_cnt), 64'(CNT_MAX)));
    end

    assign out_valid = r_out_valid;
    assign out_data  = w_main_q;
    assign stall_cnt = r_stall_cnt;

endmodule
